// File: rtl/sprite_pos_arbiter.sv
// Round-robin write arbiter for sprite positions with a shadow/active bank pair.
// Define POS_CLAMP_EN to clamp accepted positions so the 32x32 sprite stays on screen.
module sprite_pos_arbiter #(
  parameter int          NUM_SPR = 4,
  parameter logic [10:0] DEF_X   = 11'd0,
  parameter logic [10:0] DEF_Y   = 11'd0,
  parameter int          SCR_W   = 800,
  parameter int          SCR_H   = 600
) (
  input  logic                  pclk,
  input  logic                  rst,
  input  logic                  vblnk_in,
  input  logic [NUM_SPR-1:0]    req_valid,
  input  logic [NUM_SPR*11-1:0] req_xpos,
  input  logic [NUM_SPR*11-1:0] req_ypos,
  output logic [NUM_SPR-1:0]    req_ready,
  output logic [NUM_SPR*11-1:0] xpos_out,
  output logic [NUM_SPR*11-1:0] ypos_out,
  output logic [NUM_SPR-1:0]    commit_mask,
  output logic                  frame_tick
);

  localparam int PW = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;

  if (SCR_W < 32 || SCR_H < 32) begin : gBadScreen
    $error("sprite_pos_arbiter: screen must be at least 32x32");
  end

  logic [10:0]        shX_q  [NUM_SPR];
  logic [10:0]        shY_q  [NUM_SPR];
  logic [10:0]        actX_q [NUM_SPR];
  logic [10:0]        actY_q [NUM_SPR];
  logic [NUM_SPR-1:0] dirty_q;
  logic [PW-1:0]      rrPtr_q, rrPtr_d;
  logic               vblnkD_q;
  logic [NUM_SPR-1:0] commitMask_q;
  logic               frameTick_q;

  logic [NUM_SPR-1:0] grant;
  logic [PW-1:0]      grantIdx;
  logic [PW-1:0]      scanIdx;
  logic               found;
  logic [10:0]        selX, selY;
  logic [10:0]        wrX, wrY;
  logic               commit;

  // First valid requester at or after rr_ptr (cyclically) wins the grant.
  always_comb begin
    grant    = '0;
    grantIdx = '0;
    scanIdx  = '0;
    found    = 1'b0;
    selX     = '0;
    selY     = '0;
    for (int k = 0; k < NUM_SPR; k++) begin
      scanIdx = PW'((int'(rrPtr_q) + k) % NUM_SPR);
      if (!found && req_valid[scanIdx]) begin
        found          = 1'b1;
        grant[scanIdx] = 1'b1;
        grantIdx       = scanIdx;
        selX           = req_xpos[11*int'(scanIdx) +: 11];
        selY           = req_ypos[11*int'(scanIdx) +: 11];
      end
    end
  end

  always_comb begin
    rrPtr_d = rrPtr_q;
    if (found) begin
      rrPtr_d = (int'(grantIdx) == NUM_SPR-1) ? '0 : grantIdx + 1'b1;
    end
  end

`ifdef POS_CLAMP_EN
  localparam logic [10:0] MAX_X = 11'(SCR_W - 32);
  localparam logic [10:0] MAX_Y = 11'(SCR_H - 32);
  assign wrX = (selX > MAX_X) ? MAX_X : selX;
  assign wrY = (selY > MAX_Y) ? MAX_Y : selY;
`else
  assign wrX = selX;
  assign wrY = selY;
`endif

  assign commit    = vblnk_in & ~vblnkD_q;
  assign req_ready = grant;

  // A write landing on the commit edge refills the shadow and stays dirty for the next frame.
  always_ff @(posedge pclk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SPR; i++) begin
        shX_q[i]  <= DEF_X;
        shY_q[i]  <= DEF_Y;
        actX_q[i] <= DEF_X;
        actY_q[i] <= DEF_Y;
      end
      dirty_q      <= '0;
      rrPtr_q      <= '0;
      vblnkD_q     <= 1'b0;
      commitMask_q <= '0;
      frameTick_q  <= 1'b0;
    end else begin
      vblnkD_q     <= vblnk_in;
      rrPtr_q      <= rrPtr_d;
      commitMask_q <= commit ? dirty_q : '0;
      frameTick_q  <= commit;
      for (int i = 0; i < NUM_SPR; i++) begin
        if (commit && dirty_q[i]) begin
          actX_q[i] <= shX_q[i];
          actY_q[i] <= shY_q[i];
        end
        if (grant[i]) begin
          shX_q[i]   <= wrX;
          shY_q[i]   <= wrY;
          dirty_q[i] <= 1'b1;
        end else if (commit) begin
          dirty_q[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    xpos_out = '0;
    ypos_out = '0;
    for (int i = 0; i < NUM_SPR; i++) begin
      xpos_out[11*i +: 11] = actX_q[i];
      ypos_out[11*i +: 11] = actY_q[i];
    end
  end

  assign commit_mask = commitMask_q;
  assign frame_tick  = frameTick_q;

endmodule
